// File: rtl/joy_poll_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : joy_poll_sequencer
// Brief    : Sequences the shared P7 select for two DB9 pads and publishes
//            atomically committed 12-bit active-low button words.
// Config   : JOY_SIXBUTTON_EN enables the 6-button pulse train and detection.
// Revision : 1.0
// ============================================================================
module joy_poll_sequencer #(
    parameter int CYCLE_TICKS = 256
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        tick_i,
    input  logic [5:0]  joy1_i,
    input  logic [5:0]  joy2_i,
    output logic        p7_o,
    output logic [11:0] joy1_o,
    output logic [11:0] joy2_o,
    output logic        six1_o,
    output logic        six2_o,
    output logic        frame_o
);

    localparam int                c_PH_W    = $clog2(CYCLE_TICKS);
    localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(CYCLE_TICKS - 1);

    logic [c_PH_W-1:0] r_ph;
    logic              r_p7;
    logic              r_frame;
    logic              w_p7_next;
    logic              w_ph0;
    logic              w_ph2;
    logic              w_ph3;
    logic              w_ph6;
    logic [1:0][5:0]   w_pins;
    logic [1:0][11:0]  w_word;
    logic [1:0]        w_six;

    assign w_ph0 = (r_ph == c_PH_W'(0));
    assign w_ph2 = (r_ph == c_PH_W'(2));
    assign w_ph3 = (r_ph == c_PH_W'(3));
    assign w_ph6 = (r_ph == c_PH_W'(6));

`ifdef JOY_SIXBUTTON_EN
    logic w_ph4;
    logic w_ph5;
    assign w_ph4 = (r_ph == c_PH_W'(4));
    assign w_ph5 = (r_ph == c_PH_W'(5));
`endif

    assign w_pins[0] = joy1_i;
    assign w_pins[1] = joy2_i;

    // P7 level that follows the current phase's tick
    always_comb begin
        w_p7_next = 1'b1;
        if (w_ph0 || w_ph2) begin
            w_p7_next = 1'b0;
        end
`ifdef JOY_SIXBUTTON_EN
        if (w_ph4 || w_ph6) begin
            w_p7_next = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ph    <= '0;
            r_p7    <= 1'b1;
            r_frame <= 1'b0;
        end else begin
            r_frame <= 1'b0;
            if (tick_i) begin
                r_ph    <= (r_ph == c_PH_LAST) ? '0 : r_ph + 1'b1;
                r_p7    <= w_p7_next;
                r_frame <= w_ph6;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [5:0]  r_meta;
        logic [5:0]  r_sync;
        logic [7:0]  r_shadow;
        logic [11:0] r_word;
        logic        r_six;
        logic [3:0]  w_upper;
        logic        w_six_next;

`ifdef JOY_SIXBUTTON_EN
        logic r_six_det;

        assign w_six_next = r_six_det;
        assign w_upper    = r_six_det ? r_sync[3:0] : 4'hF;

        // All four directions low on the third low pulse identifies a 6-button pad
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                r_six_det <= 1'b0;
            end else if (tick_i) begin
                if (w_ph2) begin
                    r_six_det <= 1'b0;
                end else if (w_ph5 && (r_sync[3:0] == 4'h0)) begin
                    r_six_det <= 1'b1;
                end
            end
        end
`else
        assign w_six_next = 1'b0;
        assign w_upper    = 4'hF;
`endif

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                r_meta   <= 6'h3F;
                r_sync   <= 6'h3F;
                r_shadow <= 8'hFF;
                r_word   <= 12'hFFF;
                r_six    <= 1'b0;
            end else begin
                r_meta <= w_pins[gi];
                r_sync <= r_meta;
                if (tick_i) begin
                    if (w_ph2) begin
                        r_shadow[5:0] <= r_sync;
                    end
                    // R and L both low while P7 is low is the Mega Drive ID
                    if (w_ph3) begin
                        if (r_sync[3:2] == 2'b00) begin
                            r_shadow[7:6] <= r_sync[5:4];
                        end else begin
                            r_shadow[7:4] <= {2'b11, r_sync[5:4]};
                        end
                    end
                    if (w_ph6) begin
                        r_word <= {w_upper, r_shadow};
                        r_six  <= w_six_next;
                    end
                end
            end
        end

        assign w_word[gi] = r_word;
        assign w_six[gi]  = r_six;
    end

    assign p7_o    = r_p7;
    assign frame_o = r_frame;
    assign joy1_o  = w_word[0];
    assign joy2_o  = w_word[1];
    assign six1_o  = w_six[0];
    assign six2_o  = w_six[1];

endmodule
`default_nettype wire
